// File: rtl/dma_cmd_sequencer.sv
// dma_cmd_sequencer: FIFO-buffered command sequencer dispatching CPU words or running HOLD/HLDA-arbitrated DMA transfers
// Ports: clock/reset_n (async active-low); cmd_valid/cmd_word in, cmd_ready/fifo_count out (FIFO side);
// cpu_enable/cpu_word out, cpu_busy in (processor side); hold out, hlda in (bus handshake);
// dma_start/dma_length/dma_dst/dma_src out, dma_done in (DMA engine); err_zero_len, idle status out.
module dma_cmd_sequencer #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  input  logic [24:0]   cmd_word,
  output logic          cmd_ready,
  output logic [CW-1:0] fifo_count,
  output logic          cpu_enable,
  output logic [24:0]   cpu_word,
  input  logic          cpu_busy,
  output logic          hold,
  input  logic          hlda,
  output logic          dma_start,
  output logic [7:0]    dma_length,
  output logic [7:0]    dma_dst,
  output logic [7:0]    dma_src,
  input  logic          dma_done,
  output logic          err_zero_len,
  output logic          idle
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, CPU_ISSUE, CPU_WAIT, DMA_REQ, DMA_RUN, DMA_REL} state_t;
  state_t state, state_d;
  logic [24:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [24:0] head;
  logic push, pop, zero_len;
  logic [CW-1:0] count_d;
  assign head = mem[rd_ptr];
  assign zero_len = head[7:0] == 8'd0;
  assign push = cmd_valid && cmd_ready;
  always_comb begin
    state_d = state;
    pop = 1'b0;
    unique case (state)
      IDLE: if (fifo_count != '0) begin
        pop = 1'b1;
        state_d = !head[24] ? CPU_ISSUE : zero_len ? IDLE : DMA_REQ;
      end
      CPU_ISSUE: state_d = CPU_WAIT;
      CPU_WAIT:  state_d = cpu_busy ? CPU_WAIT : IDLE;
      DMA_REQ:   state_d = hlda ? DMA_RUN : DMA_REQ;
      // dma_start marks the first cycle of DMA_RUN, during which dma_done is ignored
      DMA_RUN:   state_d = (dma_done && !dma_start) ? DMA_REL : DMA_RUN;
      DMA_REL:   state_d = hlda ? DMA_REL : IDLE;
      default:   state_d = IDLE;
    endcase
    count_d = fifo_count + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= cmd_word;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      cmd_ready    <= 1'b1;
      idle         <= 1'b1;
      cpu_enable   <= 1'b0;
      cpu_word     <= '0;
      hold         <= 1'b0;
      dma_start    <= 1'b0;
      dma_length   <= '0;
      dma_dst      <= '0;
      dma_src      <= '0;
      err_zero_len <= 1'b0;
    end else begin
      state        <= state_d;
      fifo_count   <= count_d;
      cmd_ready    <= count_d < CW'(DEPTH);
      idle         <= state_d == IDLE && count_d == '0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cpu_enable   <= state_d == CPU_ISSUE;
      hold         <= state_d == DMA_REQ || state_d == DMA_RUN;
      dma_start    <= state == DMA_REQ && hlda;
      err_zero_len <= pop && head[24] && zero_len;
      if (pop && !head[24]) cpu_word <= head;
      if (pop && head[24] && !zero_len) {dma_src, dma_dst, dma_length} <= head[23:0];
    end
  end
endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// tb_dma_cmd_sequencer: randomized and directed bench for dma_cmd_sequencer against a queue-based reference model
module tb_dma_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clock = 0, reset_n = 0, cmd_valid = 0, cpu_busy = 0, hlda = 0, dma_done = 0;
  logic [24:0] cmd_word = '0;
  logic cmd_ready, cpu_enable, hold, dma_start, err_zero_len, idle;
  logic [CW-1:0] fifo_count;
  logic [24:0] cpu_word;
  logic [7:0] dma_length, dma_dst, dma_src;

  dma_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .cmd_ready(cmd_ready), .fifo_count(fifo_count), .cpu_enable(cpu_enable), .cpu_word(cpu_word),
    .cpu_busy(cpu_busy), .hold(hold), .hlda(hlda), .dma_start(dma_start), .dma_length(dma_length),
    .dma_dst(dma_dst), .dma_src(dma_src), .dma_done(dma_done), .err_zero_len(err_zero_len), .idle(idle)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: command queue plus protocol phase
  // 0 idle, 1 cpu strobe, 2 cpu wait, 3 bus request, 4 transfer launch, 5 transfer, 6 bus release
  logic [24:0] mq[$];
  int ph = 0;
  logic e_en = 0, e_start = 0, e_err = 0;
  logic [24:0] e_word = '0;
  logic [7:0] e_len = 0, e_dst = 0, e_src = 0;

  // Observed events
  int en_cnt = 0, st_cnt = 0, err_cnt = 0, hold_rises = 0;
  int en_cyc = 0, st_cyc = 0, err_cyc = 0, hold_fall = 0, idle_rise = 0;
  int hlda_rise = 0, hlda_fall = 0, busy_fall = 0, done_cyc = 0;
  logic p_hold = 0, p_idle = 1;
  logic [24:0] got_words[$];

  // Responders
  bit auto_cpu = 0, auto_hlda = 0, auto_dma = 0;
  int busy_len = 1, hlda_lat = 0, done_lat = 1, busy_left = 0, done_left = 0;
  logic [15:0] hist = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph = 0;
    {e_en, e_start, e_err} = '0;
    e_word = '0;
    {e_len, e_dst, e_src} = '0;
  endtask

  task automatic model_edge();
    logic [24:0] w;
    bit push;
    if (!reset_n) begin
      model_reset();
      return;
    end
    push = cmd_valid && mq.size() < DEPTH;
    {e_en, e_start, e_err} = '0;
    case (ph)
      0: if (mq.size() > 0) begin
        w = mq.pop_front();
        if (!w[24]) begin ph = 1; e_en = 1; e_word = w; end
        else if (w[7:0] == 0) e_err = 1;
        else begin ph = 3; e_src = w[23:16]; e_dst = w[15:8]; e_len = w[7:0]; end
      end
      1: ph = 2;
      2: if (!cpu_busy) ph = 0;
      3: if (hlda) begin ph = 4; e_start = 1; end
      4: ph = 5;
      5: if (dma_done) ph = 6;
      6: if (!hlda) ph = 0;
      default: ph = 0;
    endcase
    if (push) mq.push_back(cmd_word);
  endtask

  task automatic check_all();
    chk("fifo_count", 32'(fifo_count), mq.size());
    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("idle", idle, ph == 0 && mq.size() == 0);
    chk("cpu_enable", cpu_enable, e_en);
    chk("cpu_word", cpu_word, e_word);
    chk("hold", hold, ph >= 3 && ph <= 5);
    chk("dma_start", dma_start, e_start);
    chk("dma_length", dma_length, e_len);
    chk("dma_dst", dma_dst, e_dst);
    chk("dma_src", dma_src, e_src);
    chk("err_zero_len", err_zero_len, e_err);
    if (cpu_enable) begin en_cnt++; en_cyc = cyc; got_words.push_back(cpu_word); end
    if (dma_start) begin st_cnt++; st_cyc = cyc; end
    if (err_zero_len) begin err_cnt++; err_cyc = cyc; end
    if (hold && !p_hold) hold_rises++;
    if (!hold && p_hold) hold_fall = cyc;
    if (idle && !p_idle) idle_rise = cyc;
    p_hold = hold;
    p_idle = idle;
  endtask

  task automatic respond();
    logic nh;
    if (auto_cpu) begin
      if (cpu_enable) begin cpu_busy = 1; busy_left = busy_len; end
      else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin cpu_busy = 0; busy_fall = cyc; end
      end
    end
    if (auto_hlda) begin
      hist = {hist[14:0], hold};
      nh = hist[hlda_lat];
      if (nh && !hlda) hlda_rise = cyc;
      if (!nh && hlda) hlda_fall = cyc;
      hlda = nh;
    end
    if (auto_dma) begin
      if (dma_done) dma_done = 0;
      if (dma_start) done_left = done_lat;
      else if (done_left > 0) begin
        done_left--;
        if (done_left == 0) begin dma_done = 1; done_cyc = cyc; end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cyc++;
    check_all();
    respond();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(logic [24:0] w);
    cmd_valid = 1;
    cmd_word = w;
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_start();
    int s0 = st_cnt;
    for (int i = 0; i < 50 && st_cnt == s0; i++) step();
    chk("start_timeout", st_cnt != s0, 1);
  endtask

  task automatic async_reset();
    #2 reset_n = 0;
    model_reset();
    {cmd_valid, cpu_busy, hlda, dma_done} = '0;
    busy_left = 0;
    done_left = 0;
    hist = '0;
    #1 check_all();
    step();
    step();
    reset_n = 1;
  endtask

  initial begin
    int e0, s0, r0, h0, push_cyc;
    steps(2);
    reset_n = 1;
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_hold", hold, 0);
    chk("rst_cpu_word", cpu_word, 0);

    // CPU dispatch with 3-cycle busy
    auto_cpu = 1; busy_len = 3; auto_hlda = 1; hlda_lat = 0;
    e0 = en_cnt;
    push_word(25'b0_00000001_00000010_00000100);
    push_cyc = cyc;
    steps(15);
    chk("t1_en_pulses", en_cnt - e0, 1);
    chk("t1_en_latency", en_cyc, push_cyc + 1);
    chk("t1_cpu_word", cpu_word, 25'h0010204);
    chk("t1_idle_after_busy", idle_rise, busy_fall + 1);

    // DMA with 3-cycle grant delay and done 5 cycles after start
    hlda_lat = 3; auto_dma = 1; done_lat = 5;
    s0 = st_cnt;
    push_word(25'b1_00000000_00001010_00000100);
    steps(30);
    chk("t2_src", dma_src, 8'h00);
    chk("t2_dst", dma_dst, 8'h0A);
    chk("t2_len", dma_length, 8'h04);
    chk("t2_start_pulses", st_cnt - s0, 1);
    chk("t2_start_after_hlda", st_cyc, hlda_rise + 1);
    chk("t2_hold_fall", hold_fall, done_cyc + 1);
    chk("t2_idle_after_hlda", idle_rise, hlda_fall + 1);

    // Fill the FIFO while a DMA is stalled in the run state
    hlda_lat = 0; auto_dma = 0; busy_len = 1;
    push_word(25'h1_11_22_01);
    wait_start();
    for (int i = 0; i <= DEPTH; i++)
      push_word({1'b0, 8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i)});
    chk("t3_count_full", 32'(fifo_count), DEPTH);
    chk("t3_ready_full", cmd_ready, 0);
    got_words.delete();
    dma_done = 1;
    step();
    dma_done = 0;
    steps(60);
    chk("t3_words_run", got_words.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got_words.size(); i++)
      chk("t3_order", got_words[i], {1'b0, 8'(8'hA0 + i), 8'(8'hB0 + i), 8'(8'hC0 + i)});

    // Zero-length DMA dropped, CPU word follows
    r0 = err_cnt; h0 = hold_rises; e0 = en_cnt;
    push_word(25'h1_0A_0B_00);
    push_word(25'h0_12_34_56);
    steps(15);
    chk("t4_err_pulses", err_cnt - r0, 1);
    chk("t4_no_hold", hold_rises - h0, 0);
    chk("t4_cpu_after_err", en_cyc, err_cyc + 1);
    chk("t4_cpu_word", cpu_word, 25'h0123456);

    // Asynchronous reset during a stalled transfer with 2 words queued
    push_word(25'h1_55_66_07);
    wait_start();
    push_word(25'h0_01_01_01);
    push_word(25'h1_02_02_02);
    async_reset();
    chk("t5_hold", hold, 0);
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_dma_len", dma_length, 0);
    s0 = st_cnt; e0 = en_cnt;
    steps(10);
    chk("t5_no_start", st_cnt - s0, 0);
    chk("t5_no_cpu", en_cnt - e0, 0);

    // dma_done asserted while idle and while requesting the bus
    auto_hlda = 0; hlda = 0; dma_done = 1;
    s0 = st_cnt;
    steps(3);
    chk("t6_idle_stays", idle, 1);
    push_word(25'h1_33_44_05);
    steps(4);
    chk("t6_hold_req", hold, 1);
    chk("t6_no_start", st_cnt - s0, 0);
    hlda = 1; dma_done = 0;
    step();
    chk("t6_start", dma_start, 1);
    dma_done = 1;
    step();
    step();
    dma_done = 0; hlda = 0;
    steps(4);
    chk("t6_back_idle", idle, 1);

    // Fully random inputs
    auto_cpu = 0; auto_hlda = 0; auto_dma = 0;
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = $urandom_range(0, 9) < 4;
      cmd_word = {1'($urandom), 16'($urandom), $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom)};
      cpu_busy = 1'($urandom);
      hlda = 1'($urandom);
      dma_done = $urandom_range(0, 3) == 0;
      if (i == 700) async_reset();
      else step();
    end

    // Random pushes with protocol-following responders at random latencies
    {cmd_valid, cpu_busy, hlda, dma_done} = '0;
    busy_left = 0; done_left = 0; hist = '0;
    auto_cpu = 1; auto_hlda = 1; auto_dma = 1;
    busy_len = $urandom_range(1, 4); hlda_lat = $urandom_range(0, 4); done_lat = $urandom_range(1, 6);
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = $urandom_range(0, 9) < 3;
      cmd_word = {1'($urandom), 16'($urandom), $urandom_range(0, 4) == 0 ? 8'd0 : 8'($urandom)};
      step();
    end
    cmd_valid = 0;
    steps(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
